// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter feeding encoder42.
// Registered one-hot grants, a one-cycle bubble between owners, and forced release after HOLD_MAX.
module arbiter4_rr #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       g1,
    output logic       g2,
    output logic       g3,
    output logic       g4,
    output logic       gvalid,
    output logic       timeout
);

    localparam int unsigned CntW = $clog2(HOLD_MAX);
    localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      grant_q, grant_d;
    logic            gvalid_q, gvalid_d;
    logic            timeout_q, timeout_d;

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] win_off;
    logic [1:0] winner;
    logic       owner_req;
    logic       hold_expired;
    logic       rel;

    // Rotate req so that bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr_q +: 4];
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 2'(i);
            end
        end
        winner = ptr_q + win_off;
    end

    always_comb begin
        owner_req    = req[owner_q];
        hold_expired = (cnt_q == CntLast);
        rel          = done || !owner_req || hold_expired;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            grant_q   <= 4'b0000;
            gvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            gvalid_q  <= gvalid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        gvalid_d  = gvalid_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d  = StGrant;
                    owner_d  = winner;
                    cnt_d    = '0;
                    grant_d  = 4'b0001 << winner;
                    gvalid_d = 1'b1;
                end
            end
            StGrant: begin
                if (rel) begin
                    state_d   = StIdle;
                    ptr_d     = owner_q + 2'd1;
                    cnt_d     = '0;
                    grant_d   = 4'b0000;
                    gvalid_d  = 1'b0;
                    // Done or a dropped request takes precedence over expiry.
                    timeout_d = !done && owner_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        g1      = grant_q[0];
        g2      = grant_q[1];
        g3      = grant_q[2];
        g4      = grant_q[3];
        gvalid  = gvalid_q;
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_arbiter4_rr.sv
// Bench for arbiter4_rr: directed scenarios with literal expectations, then random traffic
// checked every cycle against an integer-level round-robin model.
module tb_arbiter4_rr;

    localparam int unsigned HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic       done = 1'b0;
    logic       g1, g2, g3, g4, gvalid, timeout;
    logic [3:0] g;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index or -1, cycles the grant has been visible, priority pointer.
    int m_owner   = -1;
    int m_held    = 0;
    int m_ptr     = 0;
    bit m_timeout = 1'b0;

    arbiter4_rr #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .g1      (g1),
        .g2      (g2),
        .g3      (g3),
        .g4      (g4),
        .gvalid  (gvalid),
        .timeout (timeout)
    );

    assign g = {g4, g3, g2, g1};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner   <= -1;
            m_held    <= 0;
            m_ptr     <= 0;
            m_timeout <= 1'b0;
        end else if (m_owner < 0) begin
            m_timeout <= 1'b0;
            if (req != 4'b0000) begin
                m_owner <= first_from(m_ptr, req);
                m_held  <= 1;
            end
        end else if (done || !req[m_owner] || m_held == HOLD_MAX) begin
            m_timeout <= !done && req[m_owner];
            m_ptr     <= (m_owner + 1) % 4;
            m_owner   <= -1;
            m_held    <= 0;
        end else begin
            m_held    <= m_held + 1;
            m_timeout <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_g;
        exp_g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("model_grant", 32'(g), 32'(exp_g));
        chk("model_gvalid", 32'(gvalid), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_timeout));
        chk("onehot0", 32'($onehot0(g)), 32'd1);
        chk("gvalid_is_or", 32'(gvalid), 32'(|g));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        // Reset held with all requests asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_rst_grant", 32'(g), 32'd0);
            chk("t1_rst_timeout", 32'(timeout), 32'd0);
        end
        rst_n = 1'b1;
        req   = 4'b1010;

        // Idle arbitration and done release.
        tick();
        chk("t2_g2", 32'(g), 32'b0010);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t2_bubble", 32'(g), 32'd0);
        tick();
        chk("t2_g4", 32'(g), 32'b1000);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t2_release", 32'(g), 32'd0);
        chk("t2_no_timeout", 32'(timeout), 32'd0);

        // Rotation with all requesting.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t3_order%0d", i), 32'(g), 32'(order[i]));
            done = 1'b1;
            tick();
            done = 1'b0;
            chk($sformatf("t3_bubble%0d", i), 32'(g), 32'd0);
        end

        // Timeout after HOLD_MAX cycles.
        req = 4'b0001;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_hold%0d", i), 32'(g), 32'b0001);
            if (i < 7) tick();
        end
        tick();
        chk("t4_expired", 32'(g), 32'd0);
        chk("t4_timeout", 32'(timeout), 32'd1);
        tick();
        chk("t4_regrant", 32'(g), 32'b0001);
        chk("t4_timeout_pulse", 32'(timeout), 32'd0);
        req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset mid-grant.
        req = 4'b0100;
        tick();
        chk("t5_g3", 32'(g), 32'b0100);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(g), 32'd0);
        chk("t5_async_gvalid", 32'(gvalid), 32'd0);
        req = 4'b1100;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t5_ptr_reset", 32'(g), 32'b0100);

        // Owner drops its request.
        done = 1'b1;
        req  = 4'b0010;
        tick();
        done = 1'b0;
        tick();
        chk("t6_g2", 32'(g), 32'b0010);
        tick();
        tick();
        chk("t6_g2_cycle3", 32'(g), 32'b0010);
        req = 4'b0000;
        tick();
        chk("t6_release", 32'(g), 32'd0);
        chk("t6_no_timeout", 32'(timeout), 32'd0);
        chk("t6_model_ptr", 32'(m_ptr), 32'd2);
        req = 4'b1111;
        tick();
        chk("t6_ptr_adv", 32'(g), 32'b0100);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
            done = ($urandom_range(5) == 0);
            if ($urandom_range(96) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
